// File: rtl/ifetch_pkg.sv
// Shared types and sizing for the instruction fetch unit.
// Defining IFETCH_SKID_EN selects a two-entry fetch buffer; otherwise it holds one entry.
package ifetch_pkg;

`ifdef IFETCH_SKID_EN
    localparam int IFETCH_DEPTH = 2;
`else
    localparam int IFETCH_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_PC = 2'd2,
        ST_FAULT   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the PC counter, instruction memory, execute and decode signals around the fetch unit.
// master is the fetch unit's view; slave is the view of the surrounding blocks.
interface instr_fetch_if;
    logic [7:0] pcAddress;
    logic [1:0] pcFlags;
    logic       pcAdvance;
    logic       sigBranch;
    logic [7:0] adding;
    logic [7:0] imemAddr;
    logic       imemReq;
    logic [7:0] imemData;
    logic       imemAck;
    logic       brTaken;
    logic [7:0] brOffset;
    logic [7:0] instr;
    logic [7:0] instrPc;
    logic       instrValid;
    logic       decReady;
    logic       fault;

    modport master (
        input  pcAddress, pcFlags, imemData, imemAck, brTaken, brOffset, decReady,
        output pcAdvance, sigBranch, adding, imemAddr, imemReq, instr, instrPc, instrValid, fault
    );

    modport slave (
        output pcAddress, pcFlags, imemData, imemAck, brTaken, brOffset, decReady,
        input  pcAdvance, sigBranch, adding, imemAddr, imemReq, instr, instrPc, instrValid, fault
    );
endinterface

// File: rtl/ifetch_buf.sv
// Small FIFO between memory responses and decode: simultaneous push/pop, flush beats both.
module ifetch_buf #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_comb begin
        o_data = r_mem[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (r_rd_ptr == PTR_W'(i)) o_data = r_mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_do_push && (r_wr_ptr == PTR_W'(i))) r_mem[i] <= i_data;
            end
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: requests one instruction per PC, steers the PC counter on branches,
// buffers {pc, instr} for decode and latches a sticky fault on PC overflow (IFETCH_SKID_EN sizes the buffer).
module instr_fetch
    import ifetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    fetch_state_t r_state;
    logic         r_fault;
    logic         w_full;
    logic         w_empty;
    logic         w_br_take;
    logic         w_push;
    logic         w_pop;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;
    logic         w_unused_flag;

    // Backward-branch flag carries no control meaning here.
    assign w_unused_flag = bus.pcFlags[0];

    // Gated by reset so that a branch pulse during reset cannot move the PC.
    assign w_br_take = bus.brTaken && reset && (r_state != ST_FAULT);
    assign w_push    = bus.imemReq && bus.imemAck && !w_br_take;
    assign w_pop     = !w_empty && bus.decReady;

    assign w_push_entry = '{pc: bus.pcAddress, instr: bus.imemData};

    assign bus.imemAddr   = bus.pcAddress;
    assign bus.imemReq    = (r_state == ST_REQ) && !w_full;
    assign bus.pcAdvance  = w_br_take || w_push;
    assign bus.sigBranch  = w_br_take;
    assign bus.adding     = w_br_take ? bus.brOffset : 8'h00;
    assign bus.instrValid = !w_empty;
    assign bus.instr      = w_head.instr;
    assign bus.instrPc    = w_head.pc;
    assign bus.fault      = r_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= w_br_take ? ST_WAIT_PC : ST_REQ;
                end
                ST_REQ: begin
                    if (w_br_take || w_push) r_state <= ST_WAIT_PC;
                end
                ST_WAIT_PC: begin
                    // The PC counter has just updated; its overflow flag is valid now.
                    if (w_br_take) begin
                        r_state <= ST_WAIT_PC;
                    end else if (bus.pcFlags[1]) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ifetch_buf #(
        .DEPTH (IFETCH_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_buf (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_br_take),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule
